// File: rtl/vga_plot_if.sv
// Plot-port bundle between drawing requesters, the plot scheduler and the VGA adapter.
// Handshake: req[i] is valid and grant[i] is ready; a plot transfers on an edge where both are high.
interface vga_plot_if #(
  parameter int NUM_REQ = 2,
  parameter int XW      = 9,
  parameter int YW      = 8,
  parameter int CW      = 12
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*XW-1:0] req_x;
  logic [NUM_REQ*YW-1:0] req_y;
  logic [NUM_REQ*CW-1:0] req_colour;
  logic [NUM_REQ-1:0]    grant;
  logic                  clear_start;
  logic [CW-1:0]         clear_colour;
  logic                  clear_busy;
  logic [XW-1:0]         out_x;
  logic [YW-1:0]         out_y;
  logic [CW-1:0]         out_colour;
  logic                  out_plot;

  modport master (
    output req, req_x, req_y, req_colour, clear_start, clear_colour,
    input  grant, clear_busy, out_x, out_y, out_colour, out_plot
  );

  modport slave (
    input  req, req_x, req_y, req_colour, clear_start, clear_colour,
    output grant, clear_busy, out_x, out_y, out_colour, out_plot
  );
endinterface

// File: rtl/vga_plot_scheduler.sv
// Round-robin sharing of the VGA adapter plot port among NUM_REQ requesters,
// with a full-screen clear sequencer that owns the port while it sweeps.
module vga_plot_scheduler #(
  parameter int NUM_REQ                 = 2,
  parameter     RESOLUTION              = "320x240",
  parameter int BITS_PER_COLOUR_CHANNEL = 4
) (
  input  logic      clock,
  input  logic      resetn,
  vga_plot_if.slave bus,
  output logic      dbg_state_o
);
  localparam bit LOWRES = (RESOLUTION == "160x120");
  localparam int XW     = LOWRES ? 8 : 9;
  localparam int YW     = LOWRES ? 7 : 8;
  localparam int CW     = 3 * BITS_PER_COLOUR_CHANNEL;
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [XW-1:0] XMAX = XW'(LOWRES ? 159 : 319);
  localparam logic [YW-1:0] YMAX = YW'(LOWRES ? 119 : 239);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        state_q;
  logic [IW-1:0] rr_q;
  logic [XW-1:0] cx_q;
  logic [YW-1:0] cy_q;
  logic [CW-1:0] clr_col_q;
  logic [XW-1:0] out_x_q;
  logic [YW-1:0] out_y_q;
  logic [CW-1:0] out_col_q;
  logic          out_plot_q;

  logic [NUM_REQ-1:0] grant_c;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [IW-1:0]      rr_d;
  int                 slot;

  // Grant is gated by reset and by a same-cycle clear_start so the clear wins ties.
  always_comb begin
    grant_c = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    slot    = 0;
    if (resetn && state_q == S_IDLE && !bus.clear_start) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        slot = int'(rr_q) + k;
        if (slot >= NUM_REQ) slot = slot - NUM_REQ;
        if (!gnt_any && bus.req[IW'(slot)]) begin
          gnt_any = 1'b1;
          gnt_idx = IW'(slot);
        end
      end
      if (gnt_any) grant_c[gnt_idx] = 1'b1;
    end
  end

  assign rr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      clr_col_q  <= '0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      out_col_q  <= '0;
      out_plot_q <= 1'b0;
    end else begin
      out_plot_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.clear_start) begin
            state_q   <= S_CLEAR;
            clr_col_q <= bus.clear_colour;
            cx_q      <= '0;
            cy_q      <= '0;
          end else if (gnt_any) begin
            out_x_q    <= bus.req_x[gnt_idx*XW +: XW];
            out_y_q    <= bus.req_y[gnt_idx*YW +: YW];
            out_col_q  <= bus.req_colour[gnt_idx*CW +: CW];
            out_plot_q <= 1'b1;
            rr_q       <= rr_d;
          end
        end
        S_CLEAR: begin
          out_x_q    <= cx_q;
          out_y_q    <= cy_q;
          out_col_q  <= clr_col_q;
          out_plot_q <= 1'b1;
          // Raster sweep; the edge that emits the last dot also leaves CLEAR.
          if (cx_q == XMAX) begin
            cx_q <= '0;
            if (cy_q == YMAX) begin
              cy_q    <= '0;
              state_q <= S_IDLE;
            end else begin
              cy_q <= cy_q + 1'b1;
            end
          end else begin
            cx_q <= cx_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_c;
  assign bus.clear_busy = (state_q == S_CLEAR);
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign bus.out_colour = out_col_q;
  assign bus.out_plot   = out_plot_q;
  assign dbg_state_o    = (state_q == S_CLEAR);
endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Bench for vga_plot_scheduler (NUM_REQ=2, 160x120): per-cycle grant/busy checks against a
// plain model, plus a negedge monitor that pops expected plots from a queue.
module tb_vga_plot_scheduler;
  localparam int N    = 2;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CW   = 12;
  localparam int XMAX = 159;
  localparam int YMAX = 119;
  localparam int NPIX = (XMAX + 1) * (YMAX + 1);
  localparam int W    = XW + YW + CW;

  // clock / reset
  logic clk = 1'b0;
  logic resetn;
  logic dbg_state;
  logic rst_drv;
  always #5 clk = ~clk;

  vga_plot_if #(.NUM_REQ(N), .XW(XW), .YW(YW), .CW(CW)) bus ();

  vga_plot_scheduler #(
    .NUM_REQ(N), .RESOLUTION("160x120"), .BITS_PER_COLOUR_CHANNEL(4)
  ) dut (
    .clock(clk), .resetn(resetn), .bus(bus.slave), .dbg_state_o(dbg_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // reference model: pointer, clear progress as a linear dot index
  int            m_rr;
  bit            m_clearing;
  int            m_pix;
  logic [CW-1:0] m_col;

  // requester side: pending plots held stable until granted
  bit            pend[N];
  logic [XW-1:0] dx[N];
  logic [YW-1:0] dy[N];
  logic [CW-1:0] dc[N];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic new_req(input int i);
    if (!pend[i]) begin
      pend[i] = 1'b1;
      dx[i]   = XW'($urandom_range(0, XMAX));
      dy[i]   = YW'($urandom_range(0, YMAX));
      dc[i]   = CW'($urandom);
    end
  endtask

  // driver: one clock cycle of stimulus plus the model step for that cycle
  task automatic cycle(input logic cs, input logic [CW-1:0] cc);
    logic [N-1:0]    r;
    logic [N*XW-1:0] vx;
    logic [N*YW-1:0] vy;
    logic [N*CW-1:0] vc;
    logic [N-1:0]    eg;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      r[i]              = pend[i];
      vx[i*XW +: XW]    = dx[i];
      vy[i*YW +: YW]    = dy[i];
      vc[i*CW +: CW]    = dc[i];
    end
    bus.req          = r;
    bus.req_x        = vx;
    bus.req_y        = vy;
    bus.req_colour   = vc;
    bus.clear_start  = cs;
    bus.clear_colour = cc;
    resetn           = rst_drv;
    #2;
    eg = '0;
    check("busy", {31'd0, bus.clear_busy}, {31'd0, m_clearing});
    if (!rst_drv) begin
      m_clearing = 1'b0;
      m_rr       = 0;
    end else if (m_clearing) begin
      exp_q.push_back({XW'(m_pix % (XMAX + 1)), YW'(m_pix / (XMAX + 1)), m_col});
      m_pix++;
      if (m_pix == NPIX) m_clearing = 1'b0;
    end else if (cs) begin
      m_clearing = 1'b1;
      m_pix      = 0;
      m_col      = cc;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (pend[i]) begin
          eg[i] = 1'b1;
          exp_q.push_back({dx[i], dy[i], dc[i]});
          pend[i] = 1'b0;
          m_rr    = (i + 1) % N;
          break;
        end
      end
    end
    check("grant", {30'd0, bus.grant}, {30'd0, eg});
  endtask

  // monitor
  always @(negedge clk) begin
    if (mon_en && bus.out_plot) begin
      logic [W-1:0] got;
      logic [W-1:0] want;
      got = {bus.out_x, bus.out_y, bus.out_colour};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL plot_extra got=%0h want=none at %0t", got, $time);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL plot got=%0h want=%0h at %0t", got, want, $time);
        end
      end
    end
  end

  initial begin
    int n;
    int rand_clears;
    logic cs;
    rst_drv          = 1'b0;
    resetn           = 1'b0;
    bus.req          = '0;
    bus.req_x        = '0;
    bus.req_y        = '0;
    bus.req_colour   = '0;
    bus.clear_start  = 1'b0;
    bus.clear_colour = '0;
    m_rr = 0; m_clearing = 1'b0; m_pix = 0; m_col = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      new_req(i);
    end
    repeat (2) @(posedge clk);
    mon_en = 1'b1;

    // reset held with every requester asserting
    repeat (3) cycle(1'b0, '0);
    check("rst_out_plot", {31'd0, bus.out_plot}, 32'd0);
    check("rst_out_x", {24'd0, bus.out_x}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);
    rst_drv = 1'b1;
    cycle(1'b0, '0);
    cycle(1'b0, '0);

    // single request from requester 1
    pend[1] = 1'b1; dx[1] = 8'd5; dy[1] = 7'd7; dc[1] = 12'hF00;
    cycle(1'b0, '0);
    cycle(1'b0, '0);

    // both requesters held continuously
    repeat (6) begin
      for (int i = 0; i < N; i++) new_req(i);
      cycle(1'b0, '0);
    end
    cycle(1'b0, '0);

    // clear colliding with a request, and a second clear_start mid-sweep
    new_req(0);
    cycle(1'b1, 12'h00F);
    n = 0;
    while (m_clearing && n < NPIX + 10) begin
      cycle(n == 5000, 12'hABC);
      n++;
    end
    cycle(1'b0, '0);
    cycle(1'b0, '0);

    // reset while the sweep is at dot (40,3)
    new_req(1);
    cycle(1'b1, 12'h0F0);
    while (m_clearing && m_pix < 3 * (XMAX + 1) + 40) cycle(1'b0, '0);
    rst_drv = 1'b0;
    cycle(1'b0, '0);
    @(posedge clk);
    #2;
    check("midrst_plot", {31'd0, bus.out_plot}, 32'd0);
    check("midrst_busy", {31'd0, bus.clear_busy}, 32'd0);
    check("midrst_x", {24'd0, bus.out_x}, 32'd0);
    check("midrst_y", {25'd0, bus.out_y}, 32'd0);
    check("midrst_col", {20'd0, bus.out_colour}, 32'd0);
    check("midrst_state", {31'd0, dbg_state}, 32'd0);
    rst_drv = 1'b1;

    // randomized traffic with at most one random clear
    rand_clears = 0;
    repeat (3000) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) new_req(i);
      cs = (!m_clearing && rand_clears == 0 && $urandom_range(0, 999) == 0);
      if (cs) rand_clears++;
      cycle(cs, CW'($urandom));
    end

    // drain
    n = 0;
    while ((m_clearing || pend[0] || pend[1] || exp_q.size() != 0) && n < NPIX + 100) begin
      cycle(1'b0, '0);
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
